// File: rtl/periph_bus_pkg.sv
// rtl/periph_bus_pkg.sv - shared state encoding and constants for periph_bus_arbiter
package periph_bus_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a priority pointer
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);

  // Scan from farthest to nearest so the requester closest to ptr is written last and wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// rtl/periph_bus_arbiter.sv - round-robin arbiter sharing one peripheral slave port
// Define PERIPH_ARB_TIMEOUT_EN to add the XFER watchdog and o_M_ERR.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                           i_CLK,
  input  logic                           i_RST,
  input  logic [NUM_MASTERS-1:0]         i_M_REQ,
  input  logic [NUM_MASTERS-1:0]         i_M_WE,
  input  logic [32*NUM_MASTERS-1:0]      i_M_ADDR,
  input  logic [32*NUM_MASTERS-1:0]      i_M_WDATA,
  output logic [NUM_MASTERS-1:0]         o_M_GNT,
  output logic [DATA_W-1:0]              o_M_RDATA,
  output logic                           o_M_ERR,
  output logic                           o_S_REQ,
  output logic [NUM_SLAVES-1:0]          o_S_CE,
  output logic                           o_S_WE,
  output logic [DATA_W-1:0]              o_S_WDATA,
  input  logic [NUM_SLAVES-1:0]          i_S_GNT,
  input  logic [32*NUM_SLAVES-1:0]       i_S_RDATA
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  arb_state_t        state_q, state_d;
  logic [MW-1:0]     owner_q, ptr_q, win;
  logic              win_valid;
  logic [SW-1:0]     sel_q;
  logic [DATA_W-1:0] rdata_q;
  logic              owner_req, slave_gnt, timeout_hit;

  logic [SW-1:0]     m_sel   [NUM_MASTERS];
  logic [DATA_W-1:0] m_wdata [NUM_MASTERS];
  logic [DATA_W-1:0] s_rdata [NUM_SLAVES];
  logic              unused_addr;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_mst
    assign m_sel[g]   = i_M_ADDR[32*g+SEL_LSB +: SW];
    assign m_wdata[g] = i_M_WDATA[32*g +: 32];
  end
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slv
    assign s_rdata[g] = i_S_RDATA[32*g +: 32];
  end
  assign unused_addr = ^i_M_ADDR;

  rr_arbiter #(.N(NUM_MASTERS), .IW(MW)) u_rr (
    .req    (i_M_REQ),
    .ptr    (ptr_q),
    .winner (win),
    .valid  (win_valid)
  );

  assign owner_req = i_M_REQ[owner_q];
  assign slave_gnt = i_S_GNT[sel_q];

`ifdef PERIPH_ARB_TIMEOUT_EN
  logic [7:0] wdt_q;
  logic       err_q;

  assign timeout_hit = (wdt_q == 8'(TIMEOUT_CYCLES - 1));
  assign o_M_ERR     = (state_q == RESP) && err_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wdt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == XFER) begin
      wdt_q <= wdt_q + 8'd1;
      err_q <= owner_req && !slave_gnt && timeout_hit;
    end else begin
      wdt_q <= '0;
    end
  end
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign o_M_ERR        = 1'b0;
`endif

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      owner_q <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (win_valid) begin
          owner_q <= win;
          sel_q   <= m_sel[win];
        end
        XFER: if (owner_req) begin
          if (slave_gnt)        rdata_q <= s_rdata[sel_q];
          else if (timeout_hit) rdata_q <= ERR_RDATA;
        end
        RESP: ptr_q <= (owner_q == MW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    o_M_GNT   = '0;
    o_M_RDATA = '0;
    o_S_REQ   = 1'b0;
    o_S_CE    = '0;
    o_S_WE    = 1'b0;
    o_S_WDATA = '0;
    case (state_q)
      IDLE: if (win_valid) state_d = XFER;
      XFER: begin
        o_S_REQ       = owner_req;
        o_S_CE[sel_q] = owner_req;
        o_S_WE        = i_M_WE[owner_q];
        o_S_WDATA     = m_wdata[owner_q];
        // A master withdrawing its request abandons the transfer before any grant.
        if (!owner_req)                    state_d = IDLE;
        else if (slave_gnt || timeout_hit) state_d = RESP;
      end
      RESP: begin
        o_M_GNT[owner_q] = 1'b1;
        o_M_RDATA        = rdata_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
